// File: rtl/fp_fmt_pkg.sv
// Shared types and width helpers for the FP result packer and its output buffer.
package fp_fmt_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic int exp_field_width(input int ew);
    return ew - 1;
  endfunction

  function automatic int packed_width(input int ew, input int sw);
    return 1 + exp_field_width(ew) + sw;
  endfunction

endpackage

// File: rtl/fmt_skid_buffer.sv
// Two-entry valid/ready buffer; in_ready is registered so the upstream path is cut.
// state     | meaning
// BUF_EMPTY | no beat held, out_valid low
// BUF_ONE   | head holds one beat, can still accept
// BUF_TWO   | head and tail full, in_ready low
module fmt_skid_buffer
  import fp_fmt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         accept_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain;

  assign accept    = in_valid & in_ready_q;
  assign drain     = (state_q != BUF_EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;
  assign accept_o  = accept;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && drain) begin
          head_d = in_data;
        end else if (accept) begin
          tail_d  = in_data;
          state_d = BUF_TWO;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BUF_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/fp_result_packer.sv
// FP add/sub output stage: IEEE special-value substitution, packing, skid buffer, sticky flags.
// Optional FMT_EVENT_CNT_EN adds saturating overflow/underflow event counters.
module fp_result_packer
  import fp_fmt_pkg::*;
#(
  parameter  int EW = 9,
  parameter  int SW = 23,
  localparam int W  = packed_width(EW, SW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign_i,
  input  logic [EW-1:0] exp_i,
  input  logic [SW-1:0] sig_i,
  input  logic          overflow_i,
  input  logic          underflow_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result_o,
  output logic          ovf_flag_o,
  output logic          unf_flag_o,
`ifdef FMT_EVENT_CNT_EN
  output logic [15:0]   ovf_cnt_o,
  output logic [15:0]   unf_cnt_o,
`endif
  input  logic          clr_flags_i
);

  localparam int XW = exp_field_width(EW);
  localparam logic [XW-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0] EXP_ZERO = '0;
  localparam logic [SW-1:0] SIG_ZERO = '0;

  logic [W-1:0] packed_word;
  logic         accept;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         ovf_evt, unf_evt;

  // The guard MSB only matters to the upstream range check, which already folded it into the flags.
  logic unused_exp_msb;
  assign unused_exp_msb = exp_i[EW-1];

  always_comb begin
    if (overflow_i)       packed_word = {sign_i, EXP_ONES, SIG_ZERO};
    else if (underflow_i) packed_word = {sign_i, EXP_ZERO, SIG_ZERO};
    else                  packed_word = {sign_i, exp_i[EW-2:0], sig_i};
  end

  fmt_skid_buffer #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (packed_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (result_o),
    .accept_o  (accept)
  );

  assign ovf_evt = accept & overflow_i;
  assign unf_evt = accept & underflow_i;

  // A set in the same cycle as a clear wins.
  assign ovf_d = ovf_evt | (ovf_q & ~clr_flags_i);
  assign unf_d = unf_evt | (unf_q & ~clr_flags_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_flag_o = ovf_q;
  assign unf_flag_o = unf_q;

`ifdef FMT_EVENT_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0] unf_cnt_q, unf_cnt_d;

  function automatic logic [15:0] cnt_next(input logic [15:0] cur, input logic evt,
                                           input logic clr);
    logic [15:0] nxt;
    nxt = cur;
    if (evt && clr)           nxt = 16'd1;
    else if (evt)             nxt = (cur == 16'hFFFF) ? cur : cur + 16'd1;
    else if (clr)             nxt = 16'd0;
    return nxt;
  endfunction

  assign ovf_cnt_d = cnt_next(ovf_cnt_q, ovf_evt, clr_flags_i);
  assign unf_cnt_d = cnt_next(unf_cnt_q, unf_evt, clr_flags_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_q <= 16'd0;
      unf_cnt_q <= 16'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
  assign unf_cnt_o = unf_cnt_q;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer (EW=9, SW=23); counter checks when FMT_EVENT_CNT_EN is set.
`timescale 1ns/1ps
module tb_fp_result_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_i = 1'b0;
  logic [8:0]  exp_i = '0;
  logic [22:0] sig_i = '0;
  logic        overflow_i = 1'b0;
  logic        underflow_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result_o;
  logic        ovf_flag_o, unf_flag_o;
  logic        clr_flags_i = 1'b0;
`ifdef FMT_EVENT_CNT_EN
  logic [15:0] ovf_cnt_o, unf_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp_result_packer #(.EW(9), .SW(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .sig_i       (sig_i),
    .overflow_i  (overflow_i),
    .underflow_i (underflow_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_o    (result_o),
    .ovf_flag_o  (ovf_flag_o),
    .unf_flag_o  (unf_flag_o),
`ifdef FMT_EVENT_CNT_EN
    .ovf_cnt_o   (ovf_cnt_o),
    .unf_cnt_o   (unf_cnt_o),
`endif
    .clr_flags_i (clr_flags_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference packing straight from the IEEE rules, using plain arithmetic.
  function automatic logic [31:0] ref_pack(input bit s, input int e, input int f,
                                           input bit o, input bit u);
    longint unsigned r;
    r = s ? 64'h8000_0000 : 64'h0;
    if (o)       r = r + 255 * (64'd1 << 23);
    else if (!u) r = r + (e % 256) * (64'd1 << 23) + f;
    return r[31:0];
  endfunction

  // Output monitor: FIFO order, value, and hold-while-stalled.
  logic        hold_v = 1'b0;
  logic [31:0] hold_val = '0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) chk("stable_while_stalled", result_o, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("result", result_o, exp_q.pop_front());
          popped++;
        end
      end
      hold_v   = out_valid & ~out_ready;
      hold_val = result_o;
    end
  end

  // Flag/counter model: evaluated at negedge, applied at the following posedge.
  bit m_ovf = 0, m_unf = 0;
  int m_ocnt = 0, m_ucnt = 0;
  always @(negedge clk) begin
    bit acc;
    if (!rst) begin
      m_ovf = 0; m_unf = 0; m_ocnt = 0; m_ucnt = 0;
    end else begin
      chk("ovf_flag", ovf_flag_o, m_ovf);
      chk("unf_flag", unf_flag_o, m_unf);
`ifdef FMT_EVENT_CNT_EN
      chk("ovf_cnt", ovf_cnt_o, m_ocnt);
      chk("unf_cnt", unf_cnt_o, m_ucnt);
`endif
      acc = in_valid && in_ready;
      if (clr_flags_i) begin m_ovf = 0; m_unf = 0; m_ocnt = 0; m_ucnt = 0; end
      if (acc && overflow_i)  begin m_ovf = 1; m_ocnt = (m_ocnt < 65535) ? m_ocnt + 1 : 65535; end
      if (acc && underflow_i) begin m_unf = 1; m_ucnt = (m_ucnt < 65535) ? m_ucnt + 1 : 65535; end
    end
  end

  task automatic send(input bit s, input int e, input int f, input bit o, input bit u,
                      input bit clr);
    bit acc;
    acc = 0;
    sign_i = s; exp_i = e[8:0]; sig_i = f[22:0];
    overflow_i = o; underflow_i = u; clr_flags_i = clr; in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back(ref_pack(s, e, f, o, u));
        pushed++;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0; clr_flags_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit rnd_done = 0;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result_o, 0);
    chk("reset_flags", {ovf_flag_o, unf_flag_o}, 0);
    rst = 1'b1;
    tick(2);

    out_ready = 1'b1;
    send(0, 9'h080, 0, 0, 0, 0);
    chk("normal_latency_valid", out_valid, 1);
    chk("normal_value", result_o, 32'h4000_0000);
    tick(1);

    send(0, 9'h0FF, 23'h12345, 1, 0, 0);
    chk("ovf_value", result_o, 32'h7F80_0000);
    tick(3);
    chk("ovf_sticky", ovf_flag_o, 1);

    send(1, 9'h000, 23'h7FFFFF, 0, 1, 0);
    chk("unf_value", result_o, 32'h8000_0000);
    tick(1);
    chk("unf_flag", unf_flag_o, 1);

    send(1, 9'h1FF, 23'h1, 1, 1, 0);
    chk("both_ovf_wins", result_o, 32'hFF80_0000);
    tick(2);

    out_ready = 1'b0;
    send(0, 9'h07F, 0, 0, 0, 0);
    send(0, 9'h080, 0, 0, 0, 0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_is_A", result_o, 32'h3F80_0000);
    tick(3);
    chk("bp_still_A", result_o, 32'h3F80_0000);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    tick(3);
    chk("bp_drained", exp_q.size(), 0);

    send(0, 9'h0FF, 0, 1, 0, 1);
    chk("clr_vs_set_ovf", ovf_flag_o, 1);
    clr_flags_i = 1'b1;
    tick(1);
    clr_flags_i = 1'b0;
    chk("clr_alone_ovf", ovf_flag_o, 0);
    chk("clr_alone_unf", unf_flag_o, 0);

    out_ready = 1'b0;
    send(1, 9'h081, 23'h55, 0, 0, 0);
    send(0, 9'h082, 23'h66, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result_o, 0);
    chk("rst_ovf_flag", ovf_flag_o, 0);
    exp_q.delete();
    pushed = 0; popped = 0;
    tick(2);
    rst = 1'b1;
    tick(2);

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 23'h7FFFFF),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 15) == 0));
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    tick(5);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_loss", popped, pushed);

`ifdef FMT_EVENT_CNT_EN
    send(0, 9'h0FF, 0, 1, 0, 1);
    chk("cnt_clr_vs_evt", ovf_cnt_o, 1);
    for (int i = 0; i < 65536; i++) send(0, 9'h0FF, 0, 1, 0, 0);
    tick(2);
    chk("cnt_saturated", ovf_cnt_o, 16'hFFFF);
    clr_flags_i = 1'b1;
    tick(1);
    clr_flags_i = 1'b0;
    chk("cnt_cleared", {ovf_cnt_o, unf_cnt_o}, 0);
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
